// File: rtl/timer_core_pkg.sv
// Shared register offsets, CTRL/STATUS bit positions and the channel mode enum.
// No logic; constants only. No flow control.
package timer_core_pkg;

    localparam int REGS_PER_CH = 4;
    localparam int OFF_COUNT   = 0;
    localparam int OFF_RELOAD  = 1;
    localparam int OFF_CTRL    = 2;
    localparam int OFF_STATUS  = 3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_DIR  = 1;
    localparam int CTRL_IRE  = 2;
    localparam int CTRL_MODE = 3;

    localparam int STAT_EXPIRED = 0;
    localparam int STAT_RUNNING = 1;

    localparam int PRESCALE_W = 16;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    function automatic int reg_idx(input int ch, input int off);
        return REGS_PER_CH * ch + off;
    endfunction

endpackage

// File: rtl/timer_core_if.sv
// Register bus between a master and timer_core: per-register strobes and read data.
// Writes land on the next clk edge; read data is combinational. No backpressure.
interface timer_core_if #(parameter int REGS = 10);
    logic [31:0]           data_in;
    logic [REGS-1:0][31:0] data_out;
    logic [REGS-1:0]       write_en;
    logic [REGS-1:0]       read_en;

    modport master (output data_in, write_en, read_en, input data_out);
    modport slave  (input data_in, write_en, read_en, output data_out);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: COUNT/RELOAD/CTRL registers plus sticky expired flag.
// Register writes and tick effects take one cycle. No backpressure; writes always accepted.
module timer_channel
    import timer_core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_count,
    input  logic             wr_reload,
    input  logic             wr_ctrl,
    input  logic             wr_status,
    input  logic [31:0]      wr_dat,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] reload,
    output logic [3:0]       ctrl,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
    logic             en_q, en_d, dir_q, dir_d, ire_q, ire_d, expired_q, expired_d;
    mode_e            mode_q, mode_d;
    logic             at_term, fire;
    logic             unused_dat;

    assign unused_dat = ^wr_dat;

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        en_d      = en_q;
        dir_d     = dir_q;
        ire_d     = ire_q;
        mode_d    = mode_q;
        expired_d = expired_q;
        at_term   = dir_q ? (count_q == reload_q) : (count_q == '0);
        // A COUNT write suppresses both the advance and any expiry this cycle.
        fire      = en_q && tick && at_term && !wr_count;

        if (wr_count) begin
            count_d = wr_dat[WIDTH-1:0];
        end else if (en_q && tick) begin
            if (!at_term) begin
                count_d = dir_q ? count_q + ONE : count_q - ONE;
            end else if (mode_q == MODE_PERIODIC) begin
                count_d = dir_q ? '0 : reload_q;
            end
        end

        if (wr_reload) begin
            reload_d = wr_dat[WIDTH-1:0];
        end

        if (wr_ctrl) begin
            en_d   = wr_dat[CTRL_EN];
            dir_d  = wr_dat[CTRL_DIR];
            ire_d  = wr_dat[CTRL_IRE];
            mode_d = mode_e'(wr_dat[CTRL_MODE]);
        end else if (fire && mode_q == MODE_ONESHOT) begin
            en_d = 1'b0;
        end

        if (fire) begin
            expired_d = 1'b1;
        end else if (wr_status && wr_dat[STAT_EXPIRED]) begin
            expired_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            reload_q  <= '0;
            en_q      <= 1'b0;
            dir_q     <= 1'b0;
            ire_q     <= 1'b0;
            mode_q    <= MODE_PERIODIC;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            en_q      <= en_d;
            dir_q     <= dir_d;
            ire_q     <= ire_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign reload  = reload_q;
    assign ctrl    = {mode_q == MODE_ONESHOT, ire_q, dir_q, en_q};
    assign expired = expired_q;

endmodule

// File: rtl/timer_core.sv
// Multi-channel timer with register decode, IRQSUM, optional prescaler (TIMER_CORE_PRESCALER_EN).
// Writes take one cycle, reads are combinational, irq_out is registered one cycle after state.
// No backpressure: every strobe is accepted in the cycle it is presented.
module timer_core
    import timer_core_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 32,
    parameter int REGS     = 4 * CHANNELS + 2
) (
    input  logic         clk,
    input  logic         reset,
    timer_core_if.slave  bus,
    output logic         irq_out
);

    localparam int IRQSUM_IDX   = REGS_PER_CH * CHANNELS;
    localparam int PRESCALE_IDX = REGS_PER_CH * CHANNELS + 1;

    logic                             tick;
    logic [31:0]                      prescale_rd;
    logic [CHANNELS-1:0]              expired, ire;
    logic [CHANNELS-1:0][WIDTH-1:0]   count, reload;
    logic [CHANNELS-1:0][3:0]         ctrl;
    logic                             irq_q, irq_d;
    logic                             unused_bus;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .wr_count  (bus.write_en[reg_idx(c, OFF_COUNT)]),
            .wr_reload (bus.write_en[reg_idx(c, OFF_RELOAD)]),
            .wr_ctrl   (bus.write_en[reg_idx(c, OFF_CTRL)]),
            .wr_status (bus.write_en[reg_idx(c, OFF_STATUS)]),
            .wr_dat    (bus.data_in),
            .count     (count[c]),
            .reload    (reload[c]),
            .ctrl      (ctrl[c]),
            .expired   (expired[c])
        );
        assign ire[c] = ctrl[c][CTRL_IRE];
    end

`ifdef TIMER_CORE_PRESCALER_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;

    always_comb begin
        prescale_d = prescale_q;
        tick       = (pcnt_q == prescale_q);
        pcnt_d     = tick ? '0 : pcnt_q + PRESCALE_W'(1);
        // Reprogramming the divider restarts the shared count from zero.
        if (bus.write_en[PRESCALE_IDX]) begin
            prescale_d = bus.data_in[PRESCALE_W-1:0];
            pcnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign prescale_rd = 32'(prescale_q);
    assign unused_bus  = ^{bus.read_en, bus.write_en[IRQSUM_IDX]};
`else
    assign tick        = 1'b1;
    assign prescale_rd = '0;
    assign unused_bus  = ^{bus.read_en, bus.write_en[IRQSUM_IDX], bus.write_en[PRESCALE_IDX]};
`endif

    always_comb begin
        bus.data_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.data_out[reg_idx(c, OFF_COUNT)]  = 32'(count[c]);
            bus.data_out[reg_idx(c, OFF_RELOAD)] = 32'(reload[c]);
            bus.data_out[reg_idx(c, OFF_CTRL)]   = 32'(ctrl[c]);
            bus.data_out[reg_idx(c, OFF_STATUS)] = 32'({ctrl[c][CTRL_EN], expired[c]});
        end
        bus.data_out[IRQSUM_IDX]   = 32'(expired);
        bus.data_out[PRESCALE_IDX] = prescale_rd;
    end

    assign irq_d = |(expired & ire);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_out = irq_q;

endmodule

// File: doc/timer_core.md
TIMER_CORE -- requirements
Module: timer_core

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 32, counter width in bits (8..32).
REQ-003 SHALL have derived parameter REGS, default 4*CHANNELS+2, number of bus-visible registers.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_in  input  32  write data from bus master.
REQ-007 SHALL have port data_out  output  32 x REGS  read data per register, combinational from state.
REQ-008 SHALL have port write_en  input  1 x REGS  per-register write strobe, single cycle.
REQ-009 SHALL have port read_en  input  1 x REGS  per-register read strobe; no read side effects.
REQ-010 SHALL have port irq_out  output  1  registered interrupt request.

Function
REQ-011 Register map SHALL be, per channel c: 4c COUNT, 4c+1 RELOAD, 4c+2 CTRL, 4c+3 STATUS; 4*CHANNELS IRQSUM; 4*CHANNELS+1 PRESCALE.
REQ-012 CTRL bits SHALL be: 0 en, 1 dir (1=up, 0=down), 2 ire, 3 mode (0=periodic, 1=one-shot); bits 31:4 read 0.
REQ-013 STATUS bits SHALL be: 0 expired (sticky, write-1-to-clear), 1 running (=en, read-only); others read 0.
REQ-014 IRQSUM bit c SHALL read expired[c]; bits >= CHANNELS read 0; writes ignored.
REQ-015 COUNT/RELOAD writes SHALL take data_in[WIDTH-1:0]; reads SHALL zero-extend to 32 bits.
REQ-016 An enabled channel SHALL advance by one (mod 2^WIDTH) on each tick.
REQ-017 Terminal value SHALL be 0 counting down and RELOAD counting up.
REQ-018 On a tick with COUNT at terminal: expired set; periodic reloads COUNT (down: RELOAD, up: 0); one-shot holds COUNT and clears en.
REQ-019 A COUNT write SHALL take priority over a same-cycle tick; no expiry fires that cycle.
REQ-020 A CTRL write SHALL take priority over a same-cycle one-shot en clear.
REQ-021 A same-cycle expiry SHALL take priority over a write-1-to-clear; expired stays 1.
REQ-022 irq_out SHALL equal, one cycle later, OR over c of (expired[c] AND ire[c]).
REQ-023 Clearing ire or expired SHALL drop irq_out on the following cycle.

Reset
REQ-024 On reset every COUNT, RELOAD, CTRL, expired, PRESCALE and the prescale counter SHALL be 0.
REQ-025 irq_out SHALL be 0 in the cycle after reset is sampled high and stay 0 while reset is held.
REQ-026 Reset SHALL override any same-cycle write or tick, including mid-count and mid-prescale.

Configuration
REQ-027 Macro TIMER_CORE_PRESCALER_EN SHALL select the prescaler feature.
REQ-028 With the macro: 16-bit PRESCALE register P and shared prescale counter; tick asserts when counter == P, then counter returns to 0; P=0 gives a tick every cycle.
REQ-029 With the macro: a PRESCALE write SHALL also zero the prescale counter.
REQ-030 Without the macro: tick SHALL be 1 every cycle; PRESCALE reads 0 and ignores writes; no prescale logic is synthesised.

Structure
REQ-031 Package timer_core_pkg SHALL hold register offsets, CTRL/STATUS bit positions, and the mode enum (MODE_PERIODIC, MODE_ONESHOT).
REQ-032 Per-channel logic SHALL be sub-module timer_channel, instantiated CHANNELS times.
REQ-033 Bus decode, IRQSUM, the prescaler and the irq_out register SHALL live in timer_core.

Verification
REQ-034 Ch0 RELOAD=5, COUNT=2, CTRL=0x5 (en, down, ire) -> ticks 2,1,0,5,4; expired set on the 0->5 tick; irq_out high one cycle later.
REQ-035 Ch1 RELOAD=3, COUNT=0, CTRL=0xB (en, up, one-shot) -> 1,2,3; the next tick sets expired, COUNT holds 3, en reads 0.
REQ-036 WIDTH=8, COUNT=0, down, RELOAD=0xFF periodic -> tick gives 0xFF; COUNT read returns 0x000000FF.
REQ-037 STATUS W1C in the same cycle as an expiry -> expired stays 1; W1C one cycle later -> expired 0, irq_out 0 the next cycle.
REQ-038 With TIMER_CORE_PRESCALER_EN, PRESCALE=3, COUNT=10 counting down -> COUNT decrements every 4 cycles; without the macro, every cycle.
REQ-039 Assert reset mid-count with COUNT=7 and PRESCALE=2 -> all registers 0 and irq_out 0 the following cycle.
